// File: rtl/panel_input_if.sv
// Front-panel bundle: raw switches/buttons in, conditioned control signals out.
interface panel_input_if #(
    parameter int unsigned N_KEYS = 7
);
    logic [2:0]        sw_mode;
    logic [1:0]        sw_pitch;
    logic [1:0]        sw_user;
    logic [N_KEYS-1:0] btn_key;
    logic              btn_pause;
    logic              btn_next;
    logic              btn_prev;

    logic [2:0]        mode;
    logic [1:0]        pitch;
    logic [1:0]        user;
    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] key_press;
    logic [1:0]        song_num;
    logic              pause;

    modport master (
        output sw_mode, sw_pitch, sw_user, btn_key, btn_pause, btn_next, btn_prev,
        input  mode, pitch, user, key, key_press, song_num, pause
    );

    modport slave (
        input  sw_mode, sw_pitch, sw_user, btn_key, btn_pause, btn_next, btn_prev,
        output mode, pitch, user, key, key_press, song_num, pause
    );
endinterface

// File: rtl/panel_input.sv
// Front-panel input conditioner: 2-FF sync and per-bit debounce of every input,
// mode legalisation, and button edge detection driving song selection and pause.
module panel_input #(
    parameter int unsigned DB_CYCLES = 2_000_000,
    parameter int unsigned N_KEYS    = 7
) (
    input logic          clk,
    input logic          rst,
    panel_input_if.slave pif
);
    localparam int unsigned NIn    = N_KEYS + 10;
    localparam int unsigned NEdge  = N_KEYS + 3;
    localparam int unsigned IdxBtn = 7;
    localparam int unsigned CntW   = $clog2(DB_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    localparam logic [2:0] ModeIdle  = 3'b000;
    localparam logic [2:0] ModeFree  = 3'b001;
    localparam logic [2:0] ModeAuto  = 3'b011;
    localparam logic [2:0] ModeLearn = 3'b111;

    // Bit map: [2:0] mode, [4:3] pitch, [6:5] user, then keys, pause, next, prev.
    logic [NIn-1:0]  raw, s1_q, s2_q, stable_q, stable_d;
    logic [CntW-1:0] cnt_q [NIn];
    logic [CntW-1:0] cnt_d [NIn];

    assign raw = {pif.btn_prev, pif.btn_next, pif.btn_pause, pif.btn_key,
                  pif.sw_user, pif.sw_pitch, pif.sw_mode};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(NIn); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Edge inputs stay disarmed after reset until their synchronised level has
    // been seen low, so a button held through reset never fires a pulse.
    logic [NEdge-1:0] btn_stb, btn_dly_q, armed_q, armed_d, rise;
    logic [1:0]       warm_q, warm_d;
    logic             warm;

    assign btn_stb = stable_q[IdxBtn +: NEdge];
    assign warm    = (warm_q == 2'd2);
    assign warm_d  = warm ? warm_q : warm_q + 2'd1;
    assign armed_d = armed_q | ({NEdge{warm}} & ~s2_q[IdxBtn +: NEdge] & ~btn_stb);
    assign rise    = btn_stb & ~btn_dly_q & armed_q;

    logic [2:0]        mode_q, mode_prev_q, mode_legal;
    logic [1:0]        pitch_q, pitch_d, user_q, song_q, song_d;
    logic [N_KEYS-1:0] key_q, key_press_q;
    logic              pause_q, pause_d, mode_chg, nxt, prv, pse;

    always_comb begin
        mode_legal = ModeIdle;
        unique case (stable_q[2:0])
            ModeIdle, ModeFree, ModeAuto, ModeLearn: mode_legal = stable_q[2:0];
            default:                                 mode_legal = ModeIdle;
        endcase
    end

    assign pitch_d  = (stable_q[4:3] == 2'b11) ? 2'b00 : stable_q[4:3];
    assign mode_chg = (mode_q != mode_prev_q);
    assign pse      = rise[N_KEYS];
    assign nxt      = rise[N_KEYS+1];
    assign prv      = rise[N_KEYS+2];

    always_comb begin
        song_d  = song_q;
        pause_d = pause_q;
        if (mode_chg) begin
            song_d  = '0;
            pause_d = 1'b0;
        end else begin
            if (mode_q == ModeAuto || mode_q == ModeLearn) begin
                if (nxt && !prv) begin
                    song_d = song_q + 2'd1;
                end else if (prv && !nxt) begin
                    song_d = song_q - 2'd1;
                end
            end
            pause_d = (mode_q == ModeAuto) ? (pause_q ^ pse) : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            stable_q    <= '0;
            for (int i = 0; i < int'(NIn); i++) cnt_q[i] <= '0;
            warm_q      <= '0;
            armed_q     <= '0;
            btn_dly_q   <= '0;
            mode_q      <= '0;
            mode_prev_q <= '0;
            pitch_q     <= '0;
            user_q      <= '0;
            key_q       <= '0;
            key_press_q <= '0;
            song_q      <= '0;
            pause_q     <= '0;
        end else begin
            s1_q        <= raw;
            s2_q        <= s1_q;
            stable_q    <= stable_d;
            for (int i = 0; i < int'(NIn); i++) cnt_q[i] <= cnt_d[i];
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            btn_dly_q   <= btn_stb;
            mode_q      <= mode_legal;
            mode_prev_q <= mode_q;
            pitch_q     <= pitch_d;
            user_q      <= stable_q[6:5];
            key_q       <= btn_stb[N_KEYS-1:0];
            key_press_q <= rise[N_KEYS-1:0];
            song_q      <= song_d;
            pause_q     <= pause_d;
        end
    end

    assign pif.mode      = mode_q;
    assign pif.pitch     = pitch_q;
    assign pif.user      = user_q;
    assign pif.key       = key_q;
    assign pif.key_press = key_press_q;
    assign pif.song_num  = song_q;
    assign pif.pause     = pause_q;
endmodule

// File: tb/tb_panel_input.sv
// Bench for panel_input: directed scenarios with constant expectations, then
// randomized stimulus against a behavioural model of the conditioning rules.
module tb_panel_input;
    localparam int unsigned NK  = 7;
    localparam int unsigned DB  = 4;
    localparam int unsigned NIN = NK + 10;
    localparam int unsigned NE  = NK + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    panel_input_if #(.N_KEYS(NK)) pif ();
    panel_input #(.DB_CYCLES(DB), .N_KEYS(NK)) dut (.clk(clk), .rst(rst), .pif(pif));

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    logic [NIN-1:0] rawv;
    assign rawv = {pif.btn_prev, pif.btn_next, pif.btn_pause, pif.btn_key,
                   pif.sw_user, pif.sw_pitch, pif.sw_mode};

    logic [NIN-1:0] m_h1, m_h2, m_stb, m_last, n_h1, n_h2, n_stb, n_last;
    int unsigned    m_run [NIN];
    int unsigned    n_run [NIN];
    int unsigned    m_warm, n_warm;
    logic [NE-1:0]  m_armed, n_armed, m_rise;
    logic [2:0]     m_mode, m_mode_prev, n_mode, n_mode_prev;
    logic [1:0]     m_pitch, m_user, m_song, n_pitch, n_user, n_song;
    logic [NK-1:0]  m_key, m_kp, n_key, n_kp;
    logic           m_pause, n_pause, m_chg;

    function automatic logic [2:0] legal(input logic [2:0] m);
        return (m == 3'd0 || m == 3'd1 || m == 3'd3 || m == 3'd7) ? m : 3'd0;
    endfunction

    assign m_rise = m_stb[7 +: NE] & ~m_last[7 +: NE] & m_armed;
    assign m_chg  = (m_mode != m_mode_prev);

    always_comb begin
        n_h1 = rawv;
        n_h2 = m_h1;
        n_stb = m_stb;
        n_run = m_run;
        // A level is accepted after DB consecutive synchronised samples disagree.
        for (int i = 0; i < int'(NIN); i++) begin
            if (m_h2[i] != m_stb[i]) begin
                if (m_run[i] + 1 >= DB) begin
                    n_stb[i] = m_h2[i];
                    n_run[i] = 0;
                end else begin
                    n_run[i] = m_run[i] + 1;
                end
            end else begin
                n_run[i] = 0;
            end
        end
        n_warm  = (m_warm < 2) ? m_warm + 1 : 2;
        n_armed = m_armed;
        if (m_warm == 2) n_armed = m_armed | (~m_h2[7 +: NE] & ~m_stb[7 +: NE]);
        n_last      = m_stb;
        n_key       = m_stb[7 +: NK];
        n_kp        = m_rise[NK-1:0];
        n_pitch     = (m_stb[4:3] == 2'b11) ? 2'b00 : m_stb[4:3];
        n_user      = m_stb[6:5];
        n_mode      = legal(m_stb[2:0]);
        n_mode_prev = m_mode;
        if (m_chg) begin
            n_song  = 2'd0;
            n_pause = 1'b0;
        end else begin
            n_song  = (m_mode == 3'd3 || m_mode == 3'd7)
                      ? m_song + {1'b0, m_rise[NK+1]} - {1'b0, m_rise[NK+2]} : m_song;
            n_pause = (m_mode == 3'd3) ? (m_pause ^ m_rise[NK]) : 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h1 <= '0; m_h2 <= '0; m_stb <= '0; m_last <= '0;
            m_run <= '{default: 0};
            m_warm <= 0; m_armed <= '0;
            m_mode <= '0; m_mode_prev <= '0; m_pitch <= '0; m_user <= '0;
            m_key <= '0; m_kp <= '0; m_song <= '0; m_pause <= 1'b0;
        end else begin
            m_h1 <= n_h1; m_h2 <= n_h2; m_stb <= n_stb; m_last <= n_last;
            m_run <= n_run;
            m_warm <= n_warm; m_armed <= n_armed;
            m_mode <= n_mode; m_mode_prev <= n_mode_prev; m_pitch <= n_pitch;
            m_user <= n_user; m_key <= n_key; m_kp <= n_kp;
            m_song <= n_song; m_pause <= n_pause;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NIN-1:0] r);
        pif.sw_mode   = r[2:0];
        pif.sw_pitch  = r[4:3];
        pif.sw_user   = r[6:5];
        pif.btn_key   = r[7 +: NK];
        pif.btn_pause = r[NK+7];
        pif.btn_next  = r[NK+8];
        pif.btn_prev  = r[NK+9];
    endtask

    // which: 0 pause, 1 next, 2 prev
    task automatic press(input int which);
        if (which == 0) pif.btn_pause = 1'b1;
        if (which == 1) pif.btn_next  = 1'b1;
        if (which == 2) pif.btn_prev  = 1'b1;
        cyc(8);
        pif.btn_pause = 1'b0;
        pif.btn_next  = 1'b0;
        pif.btn_prev  = 1'b0;
        cyc(8);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive('0);
        cyc(3);
        vectors++;
        if ({pif.mode, pif.pitch, pif.user, pif.key, pif.key_press, pif.song_num, pif.pause}
            !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got mode=%b song=%0d pause=%b key=%b want all 0",
                     pif.mode, pif.song_num, pif.pause, pif.key);
        end
        rst = 1'b0;
        cyc(5);
        vectors++;
        if (pif.key_press !== '0 || pif.pause !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_pulse: got key_press=%b pause=%b want 0",
                     pif.key_press, pif.pause);
        end
    endtask

    task automatic test_bounce();
        logic v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v = ~v;
            pif.btn_key[0] = v;
            for (int k = 0; k < 2; k++) begin
                cyc(1);
                vectors++;
                if (pif.key[0] !== 1'b0 || pif.key_press[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bounce_hidden: got key=%b press=%b want 0 0",
                             pif.key[0], pif.key_press[0]);
                end
            end
        end
        pif.btn_key[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            vectors++;
            if (pif.key[0] !== logic'(k >= 7) || pif.key_press[0] !== logic'(k == 7)) begin
                miscompares++;
                $display("FAIL key_rise cyc %0d: got key=%b press=%b want %b %b", k,
                         pif.key[0], pif.key_press[0], logic'(k >= 7), logic'(k == 7));
            end
        end
        pif.btn_key[0] = 1'b0;
        cyc(10);
    endtask

    task automatic test_song_select();
        int exp_s[5] = '{1, 2, 3, 0, 1};
        pif.sw_mode = 3'b011;
        cyc(10);
        vectors++;
        if (pif.mode !== 3'b011 || pif.song_num !== 2'd0) begin
            miscompares++;
            $display("FAIL auto_entry: got mode=%b song=%0d want 011 0", pif.mode, pif.song_num);
        end
        for (int i = 0; i < 5; i++) begin
            press(1);
            vectors++;
            if (pif.song_num !== 2'(exp_s[i])) begin
                miscompares++;
                $display("FAIL next_%0d: got song=%0d want %0d", i, pif.song_num, exp_s[i]);
            end
        end
        for (int i = 0; i < 3; i++) press(1);
        vectors++;
        if (pif.song_num !== 2'd0) begin
            miscompares++;
            $display("FAIL next_wrap: got song=%0d want 0", pif.song_num);
        end
        press(2);
        vectors++;
        if (pif.song_num !== 2'd3) begin
            miscompares++;
            $display("FAIL prev_wrap: got song=%0d want 3", pif.song_num);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) press(1);
        pif.btn_next = 1'b1;
        pif.btn_prev = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc(1);
            vectors++;
            if (pif.song_num !== 2'd2) begin
                miscompares++;
                $display("FAIL next_prev_same cyc %0d: got song=%0d want 2", k, pif.song_num);
            end
        end
        pif.btn_next = 1'b0;
        pif.btn_prev = 1'b0;
        cyc(8);
    endtask

    task automatic test_pause();
        logic exp_p[3] = '{1'b1, 1'b0, 1'b1};
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            press(0);
            vectors++;
            if (pif.pause !== exp_p[i]) begin
                miscompares++;
                $display("FAIL pause_toggle_%0d: got %b want %b", i, pif.pause, exp_p[i]);
            end
        end
        pif.sw_mode = 3'b001;
        do begin
            cyc(1);
            n++;
        end while (pif.mode !== 3'b001 && n < 20);
        vectors++;
        if (pif.mode !== 3'b001 || n != 7) begin
            miscompares++;
            $display("FAIL mode_free_latency: got mode=%b after %0d cyc want 001 after 7",
                     pif.mode, n);
        end
        vectors++;
        if (pif.pause !== 1'b1 || pif.song_num !== 2'd2) begin
            miscompares++;
            $display("FAIL mode_edge_hold: got pause=%b song=%0d want 1 2", pif.pause, pif.song_num);
        end
        cyc(1);
        vectors++;
        if (pif.pause !== 1'b0 || pif.song_num !== 2'd0) begin
            miscompares++;
            $display("FAIL mode_change_clear: got pause=%b song=%0d want 0 0",
                     pif.pause, pif.song_num);
        end
    endtask

    task automatic test_legalise();
        pif.sw_mode  = 3'b010;
        pif.sw_pitch = 2'b11;
        pif.sw_user  = 2'b10;
        cyc(10);
        vectors++;
        if (pif.mode !== 3'b000 || pif.pitch !== 2'b00 || pif.user !== 2'b10) begin
            miscompares++;
            $display("FAIL illegal_010: got mode=%b pitch=%b user=%b want 000 00 10",
                     pif.mode, pif.pitch, pif.user);
        end
        pif.sw_mode = 3'b101;
        cyc(10);
        vectors++;
        if (pif.mode !== 3'b000) begin
            miscompares++;
            $display("FAIL illegal_101: got mode=%b want 000", pif.mode);
        end
        pif.sw_mode  = 3'b111;
        pif.sw_pitch = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            vectors++;
            if (pif.mode !== ((k >= 7) ? 3'b111 : 3'b000)
                || pif.pitch !== ((k >= 7) ? 2'b01 : 2'b00)) begin
                miscompares++;
                $display("FAIL learn_latency cyc %0d: got mode=%b pitch=%b", k, pif.mode, pif.pitch);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        pif.sw_mode = 3'b011;
        cyc(10);
        pif.btn_pause = 1'b1;
        cyc(3);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({pif.mode, pif.pitch, pif.user, pif.key, pif.key_press, pif.song_num, pif.pause}
            !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got mode=%b pitch=%b user=%b pause=%b want all 0",
                     pif.mode, pif.pitch, pif.user, pif.pause);
        end
        cyc(2);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            vectors++;
            if (pif.pause !== 1'b0) begin
                miscompares++;
                $display("FAIL held_through_reset cyc %0d: got pause=%b want 0", k, pif.pause);
            end
        end
        pif.btn_pause = 1'b0;
        cyc(10);
        vectors++;
        if (pif.pause !== 1'b0 || pif.mode !== 3'b011) begin
            miscompares++;
            $display("FAIL release_after_reset: got pause=%b mode=%b want 0 011",
                     pif.pause, pif.mode);
        end
        press(0);
        vectors++;
        if (pif.pause !== 1'b1) begin
            miscompares++;
            $display("FAIL fresh_press: got pause=%b want 1", pif.pause);
        end
        press(0);
    endtask

    task automatic test_random(input int n);
        logic [NIN-1:0] r;
        for (int c = 0; c < n; c++) begin
            r = rawv;
            for (int b = 0; b < int'(NIN); b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            drive(r);
            cyc(1);
            vectors++;
            if (pif.mode !== m_mode || pif.pitch !== m_pitch || pif.user !== m_user) begin
                miscompares++;
                $display("FAIL rnd_levels cyc %0d: got mode=%b pitch=%b user=%b want %b %b %b",
                         c, pif.mode, pif.pitch, pif.user, m_mode, m_pitch, m_user);
            end
            vectors++;
            if (pif.key !== m_key || pif.key_press !== m_kp) begin
                miscompares++;
                $display("FAIL rnd_keys cyc %0d: got key=%b press=%b want %b %b",
                         c, pif.key, pif.key_press, m_key, m_kp);
            end
            vectors++;
            if (pif.song_num !== m_song || pif.pause !== m_pause) begin
                miscompares++;
                $display("FAIL rnd_song cyc %0d: got song=%0d pause=%b want %0d %b",
                         c, pif.song_num, pif.pause, m_song, m_pause);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_song_select();
        test_simultaneous();
        test_pause();
        test_legalise();
        test_reset_mid_debounce();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
